// File: rtl/fsm_float_to_fixed_ctrl.sv
// Sequencer for the float-to-fixed datapath: CLR, LOAD_F, CMP, SEL, SHIFT, STORE, DONE.
// Outputs are registered decodes of the next state; RDY holds until ACK_FSM, ERR flags out-of-window shifts.
module fsm_float_to_fixed_ctrl #(
    parameter int SHIFT_LAT = 1,
    parameter int MAX_SHIFT = 26,
    parameter int BIAS      = 127
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       BEGIN_FSM,
    input  logic       ACK_FSM,
    input  logic [7:0] Exp,
    output logic       RST_DP,
    output logic       EN_REG1,
    output logic       MS_1,
    output logic       LOAD,
    output logic       EN_REG2,
    output logic       BUSY,
    output logic       RDY,
    output logic       ERR
);
    typedef enum logic [2:0] {
        S_IDLE, S_CLR, S_LOAD_F, S_CMP, S_SEL, S_SHIFT, S_STORE, S_DONE
    } state_t;

    localparam logic [2:0] CNT_LAST = 3'(SHIFT_LAT - 1);
    localparam logic [8:0] BIAS9    = 9'(BIAS);
    localparam logic [8:0] MAX9     = 9'(MAX_SHIFT);

    state_t     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic       eq_flag_q, eq_flag_d;
    logic       err_q, err_d;
    logic       rst_dp_q, rst_dp_d;
    logic       en_reg1_q, en_reg1_d;
    logic       ms_1_q, ms_1_d;
    logic       load_q, load_d;
    logic       en_reg2_q, en_reg2_d;
    logic       busy_q, busy_d;
    logic       rdy_q, rdy_d;

    logic [8:0] exp9, diff_up, diff_dn, shift_mag;

    // Magnitude of the unbiased exponent, taken in whichever direction does not wrap.
    assign exp9      = {1'b0, Exp};
    assign diff_up   = exp9 - BIAS9;
    assign diff_dn   = BIAS9 - exp9;
    assign shift_mag = (exp9 >= BIAS9) ? diff_up : diff_dn;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        eq_flag_d = eq_flag_q;
        err_d     = err_q;
        case (state_q)
            S_IDLE: begin
                if (BEGIN_FSM) begin
                    state_d = S_CLR;
                    err_d   = 1'b0;
                end
            end
            S_CLR:    state_d = S_LOAD_F;
            S_LOAD_F: state_d = S_CMP;
            S_CMP: begin
                eq_flag_d = (exp9 == BIAS9);
                err_d     = (shift_mag > MAX9);
                state_d   = S_SEL;
            end
            S_SEL: begin
                cnt_d   = 3'd0;
                state_d = S_SHIFT;
            end
            S_SHIFT: begin
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == CNT_LAST) begin
                    state_d = S_STORE;
                end
            end
            S_STORE: state_d = S_DONE;
            S_DONE: begin
                if (ACK_FSM) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Decoding the next state makes every strobe a flop that is aligned with its state.
        rst_dp_d  = (state_d == S_CLR);
        en_reg1_d = (state_d == S_LOAD_F);
        load_d    = (state_d == S_SHIFT);
        en_reg2_d = (state_d == S_STORE);
        rdy_d     = (state_d == S_DONE);
        ms_1_d    = ~eq_flag_d & ((state_d == S_SEL) || (state_d == S_SHIFT) || (state_d == S_STORE));
        busy_d    = (state_d == S_CLR) || (state_d == S_LOAD_F) || (state_d == S_CMP) ||
                    (state_d == S_SEL) || (state_d == S_SHIFT) || (state_d == S_STORE);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= S_IDLE;
            cnt_q     <= 3'd0;
            eq_flag_q <= 1'b0;
            err_q     <= 1'b0;
            rst_dp_q  <= 1'b0;
            en_reg1_q <= 1'b0;
            ms_1_q    <= 1'b0;
            load_q    <= 1'b0;
            en_reg2_q <= 1'b0;
            busy_q    <= 1'b0;
            rdy_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            eq_flag_q <= eq_flag_d;
            err_q     <= err_d;
            rst_dp_q  <= rst_dp_d;
            en_reg1_q <= en_reg1_d;
            ms_1_q    <= ms_1_d;
            load_q    <= load_d;
            en_reg2_q <= en_reg2_d;
            busy_q    <= busy_d;
            rdy_q     <= rdy_d;
        end
    end

    assign RST_DP  = rst_dp_q;
    assign EN_REG1 = en_reg1_q;
    assign MS_1    = ms_1_q;
    assign LOAD    = load_q;
    assign EN_REG2 = en_reg2_q;
    assign BUSY    = busy_q;
    assign RDY     = rdy_q;
    assign ERR     = err_q;

endmodule

// File: tb/tb_fsm_float_to_fixed_ctrl.sv
// Bench for fsm_float_to_fixed_ctrl: SHIFT_LAT=1 and SHIFT_LAT=3 instances checked every cycle
// against a step-count model of a conversion, plus directed latency, reset and back-to-back runs.
module tb_fsm_float_to_fixed_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, bg, ack1, ack3;
    logic [7:0] exp_v;
    // Output vectors: {RST_DP, EN_REG1, MS_1, LOAD, EN_REG2, BUSY, RDY, ERR}
    wire  [7:0] o1, o3;

    int total = 0;
    int bad   = 0;

    fsm_float_to_fixed_ctrl #(.SHIFT_LAT(1)) u_dut1 (
        .CLK(clk), .RST(rst), .BEGIN_FSM(bg), .ACK_FSM(ack1), .Exp(exp_v),
        .RST_DP(o1[7]), .EN_REG1(o1[6]), .MS_1(o1[5]), .LOAD(o1[4]),
        .EN_REG2(o1[3]), .BUSY(o1[2]), .RDY(o1[1]), .ERR(o1[0])
    );

    fsm_float_to_fixed_ctrl #(.SHIFT_LAT(3)) u_dut3 (
        .CLK(clk), .RST(rst), .BEGIN_FSM(bg), .ACK_FSM(ack3), .Exp(exp_v),
        .RST_DP(o3[7]), .EN_REG1(o3[6]), .MS_1(o3[5]), .LOAD(o3[4]),
        .EN_REG2(o3[3]), .BUSY(o3[2]), .RDY(o3[1]), .ERR(o3[0])
    );

    // pos counts cycles into a conversion: 0 idle, 1 clear, 2 float load, 3 compare, 4 select,
    // 5..4+lat shifting, 5+lat store, 6+lat waiting for acknowledge.
    typedef struct packed {
        logic [7:0] pos;
        logic       err;
        logic       eq;
    } mdl_t;

    function automatic mdl_t mdl_step(mdl_t m, int lat, logic r, logic b, logic a, logic [7:0] e);
        mdl_t n;
        int   mag;
        n   = m;
        mag = (int'(e) >= 127) ? int'(e) - 127 : 127 - int'(e);
        if (r) begin
            n = '0;
        end else if (m.pos == 8'd0) begin
            if (b) begin
                n.pos = 8'd1;
                n.err = 1'b0;
            end
        end else if (int'(m.pos) == 6 + lat) begin
            if (a) n.pos = 8'd0;
        end else begin
            if (m.pos == 8'd3) begin
                n.err = (mag > 26);
                n.eq  = (e == 8'd127);
            end
            n.pos = m.pos + 8'd1;
        end
        return n;
    endfunction

    function automatic logic [7:0] mdl_out(mdl_t m, int lat);
        int p;
        p = int'(m.pos);
        return {p == 1, p == 2, !m.eq && p >= 4 && p <= 5 + lat, p >= 5 && p <= 4 + lat,
                p == 5 + lat, p >= 1 && p <= 5 + lat, p == 6 + lat, m.err};
    endfunction

    function automatic mdl_t run_conv(logic [7:0] e, int lat, int steps);
        mdl_t m;
        m = mdl_step('0, lat, 1'b0, 1'b1, 1'b0, e);
        for (int i = 1; i < steps; i++) m = mdl_step(m, lat, 1'b0, 1'b0, 1'b0, e);
        return m;
    endfunction

    mdl_t m1 = '0;
    mdl_t m3 = '0;
    always @(posedge clk) begin
        m1 <= mdl_step(m1, 1, rst, bg, ack1, exp_v);
        m3 <= mdl_step(m3, 3, rst, bg, ack3, exp_v);
    end

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Advance to the middle of the next cycle and compare both instances against the model.
    task automatic tick();
        @(negedge clk);
        chk("dut1_outputs", o1, mdl_out(m1, 1));
        chk("dut3_outputs", o3, mdl_out(m3, 3));
        chk("dut1_onehot", {7'd0, $countones({o1[7], o1[6], o1[4], o1[3]}) <= 1}, 8'd1);
        chk("dut3_onehot", {7'd0, $countones({o3[7], o3[6], o3[4], o3[3]}) <= 1}, 8'd1);
    endtask

    task automatic conv(input logic [7:0] e, input bit pulse_mid, output int l1, output int l3);
        l1    = 0;
        l3    = 0;
        exp_v = e;
        bg    = 1'b1;
        for (int c = 1; c <= 40 && l3 == 0; c++) begin
            tick();
            bg = (pulse_mid && c == 5);
            if (l1 == 0 && o1[1]) l1 = c;
            if (l3 == 0 && o3[1]) l3 = c;
        end
        bg = 1'b0;
    endtask

    task automatic ack_both();
        ack1 = 1'b1;
        ack3 = 1'b1;
        tick();
        ack1 = 1'b0;
        ack3 = 1'b0;
    endtask

    int l1, l3, cyc;
    int q1[$];
    int q3[$];

    initial begin
        rst   = 1'b1;
        bg    = 1'b0;
        ack1  = 1'b0;
        ack3  = 1'b0;
        exp_v = 8'h7F;

        // Hand-computed expectations that pin the model.
        chk("pin_done_pos_lat1", run_conv(8'h7F, 1, 7).pos, 8'd7);
        chk("pin_done_pos_lat3", run_conv(8'h7F, 3, 9).pos, 8'd9);
        chk("pin_done_out_7f", mdl_out(run_conv(8'h7F, 1, 7), 1), 8'b0000_0010);
        chk("pin_shift_out_80", mdl_out(run_conv(8'h80, 1, 5), 1), 8'b0011_0100);
        chk("pin_shift_out_7f", mdl_out(run_conv(8'h7F, 1, 5), 1), 8'b0001_0100);
        chk("pin_err_9a", {7'd0, run_conv(8'h9A, 1, 7).err}, 8'd1);
        chk("pin_err_64", {7'd0, run_conv(8'h64, 1, 7).err}, 8'd1);
        chk("pin_err_99", {7'd0, run_conv(8'h99, 1, 7).err}, 8'd0);
        chk("pin_err_65", {7'd0, run_conv(8'h65, 1, 7).err}, 8'd0);

        tick();
        tick();
        chk("reset_dut1", o1, 8'd0);
        chk("reset_dut3", o3, 8'd0);
        rst = 1'b0;
        tick();

        // Zero shift, with a start pulse during SHIFT that must be ignored.
        conv(8'h7F, 1'b1, l1, l3);
        chk("lat_rdy_dut1", 8'(l1), 8'd7);
        chk("lat_rdy_dut3", 8'(l3), 8'd9);
        for (int i = 0; i < 4; i++) tick();
        ack_both();
        tick();
        tick();
        chk("idle_after_ack_dut1", {7'd0, o1[2] | o1[1]}, 8'd0);
        chk("idle_after_ack_dut3", {7'd0, o3[2] | o3[1]}, 8'd0);

        foreach (q1[i]) q1.delete(i);
        conv(8'h9A, 1'b0, l1, l3);
        chk("err_9a_dut1", {7'd0, o1[0]}, 8'd1);
        ack_both();
        tick();

        // Reset in the middle of SHIFT.
        bg = 1'b1;
        tick();
        bg = 1'b0;
        for (int i = 2; i <= 5; i++) tick();
        rst = 1'b1;
        tick();
        chk("mid_reset_dut1", o1, 8'd0);
        chk("mid_reset_dut3", o3, 8'd0);
        rst = 1'b0;
        tick();
        conv(8'h80, 1'b0, l1, l3);
        chk("post_reset_lat_dut1", 8'(l1), 8'd7);
        chk("post_reset_lat_dut3", 8'(l3), 8'd9);
        ack_both();
        tick();

        // Start held high, each instance acknowledged in its first DONE cycle.
        bg    = 1'b1;
        exp_v = 8'h64;
        cyc   = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            cyc++;
            ack1 = o1[1];
            ack3 = o3[1];
            if (o1[7]) q1.push_back(cyc);
            if (o3[7]) q3.push_back(cyc);
        end
        bg = 1'b0;
        chk("b2b_count_dut1", {7'd0, q1.size() >= 5}, 8'd1);
        chk("b2b_count_dut3", {7'd0, q3.size() >= 4}, 8'd1);
        for (int i = 1; i < q1.size(); i++) chk("b2b_period_dut1", 8'(q1[i] - q1[i-1]), 8'd8);
        for (int i = 1; i < q3.size(); i++) chk("b2b_period_dut3", 8'(q3[i] - q3[i-1]), 8'd10);
        for (int i = 0; i < 20; i++) begin
            tick();
            ack1 = o1[1];
            ack3 = o3[1];
        end
        ack1 = 1'b0;
        ack3 = 1'b0;

        // Random traffic, including sporadic resets and boundary exponents.
        for (int i = 0; i < 3000; i++) begin
            tick();
            rst  = ($urandom_range(0, 99) == 0);
            bg   = ($urandom_range(0, 3) == 0);
            ack1 = ($urandom_range(0, 2) == 0);
            ack3 = ($urandom_range(0, 2) == 0);
            case ($urandom_range(0, 8))
                0:       exp_v = 8'h00;
                1:       exp_v = 8'hFF;
                2:       exp_v = 8'h7F;
                3:       exp_v = 8'h80;
                4:       exp_v = 8'h9A;
                5:       exp_v = 8'h99;
                6:       exp_v = 8'h64;
                7:       exp_v = 8'h65;
                default: exp_v = 8'($urandom);
            endcase
        end
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
